data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Byte-addressed data-memory responder sitting on the far side of the core's data port (`mem_addr`, `mem_data_in`, `mem_write_en`, `mem_data_out`). It serves the cache's word-wide fill and write-back traffic with a configurable fixed access latency. It also raises `mem_ready` once the currently presented request has been serviced. The core has no request strobe, so the block detects new requests by comparing against the last captured request.

## Interface
Parameters:
- `ADDR_BITS`, default 12: storage holds 2^ADDR_BITS bytes; address bits above this are ignored (wrap).
- `LATENCY`, default 4: cycles from request capture to completion; legal range ≥1.

Ports:
- `clk`  input  1: sole clock, rising edge.
- `rst_b`  input  1: reset, asynchronous, active-low.
- `mem_addr`  input  32: byte address of the access; bits [1:0] ignored (word-aligned).
- `mem_data_in`  input  8 × [0:3]: write bytes; lane i goes to byte base+i.
- `mem_write_en`  input  1: 1 = write request, 0 = read request.
- `mem_data_out`  output  8 × [0:3]: read data; lane i = byte base+i.
- `mem_ready`  output  1: current request has completed; outputs valid.

## Operation
- Word base = {mem_addr[ADDR_BITS-1:2], 2'b00}.
- Captured request = {base, mem_write_en, and mem_data_in when writing}.
- Storage is a byte array and is not cleared by reset.
- States:
  - IDLE: at the next edge, capture the request, load `cnt` = LATENCY-1, go to WAIT.
  - WAIT:
    - If the live request differs from the captured one, re-capture it, reload `cnt`, stay in WAIT. The abandoned write is not performed.
    - Else if `cnt`==0, complete and go to DONE.
    - Else decrement `cnt`.
  - DONE: hold while the live request equals the captured one. On any difference, re-capture, reload `cnt`, go to WAIT, drop `mem_ready`.
- Completion of a read: `mem_data_out[i]` <= mem[base+i]; `mem_ready` <= 1.
- Completion of a write:
  - mem[base+i] <= `mem_data_in[i]` for i=0..3, exactly once.
  - `mem_data_out` <= the written bytes (read-after-write value); `mem_ready` <= 1.
- A write is never repeated while in DONE, even though the request stays asserted.
- Read data for a word written in an earlier transaction always reflects that write.
- Reading an address never written returns the storage's initial contents (X in simulation unless preloaded).

## Timing
- Reset (asynchronous assert, any state):
  - State IDLE, `cnt` = 0, `mem_ready` = 0, all `mem_data_out` lanes = 8'h00, captured request cleared.
  - A pending write is discarded; storage is untouched.
- First rising edge after `rst_b` deasserts is the capture edge c.
- Completion happens at edge c+LATENCY; `mem_ready` and `mem_data_out` are registered and visible after that edge.
  - LATENCY=1: ready after edge c+1.
  - LATENCY=4: ready after edge c+4.
- A request change sampled at edge e re-captures at e. `mem_ready` is 0 after e, and completion occurs at e+LATENCY.
- `mem_data_out` holds its last completed value while `mem_ready` is 0. Consumers must not use it until `mem_ready`=1.
- Address change only in bits [1:0], or above ADDR_BITS: not a new request.
- `mem_data_in` change while `mem_write_en`=0: not a new request.
- Write followed by a read of the same word with no idle cycle: the read completes LATENCY edges after its capture and returns the new data.

## Test plan
- Reset: assert `rst_b`=0 mid-WAIT → `mem_ready`=0 and `mem_data_out`={00,00,00,00} immediately (no clock needed). After release, state is IDLE.
- Write/read, LATENCY=4:
  - Write addr 0x10, data {DE,AD,BE,EF}, held → `mem_ready` rises after the 4th edge past capture; memory written once.
  - Then read 0x10 → ready drops for 4 edges, then `mem_data_out`={DE,AD,BE,EF}.
- Restart: read 0x20, change to 0x24 after 2 edges → ready stays 0 until 4 edges after the change; data comes from 0x24.
- Abandoned write: write 0x30={11,22,33,44}, switch to a read of 0x30 after 1 edge → old contents returned and 0x30 unchanged.
- Aliasing: addr 0x1002 with ADDR_BITS=12 → same word as 0x000; no new request when only bits [1:0] toggle in DONE (`mem_ready` stays 1).
- LATENCY=1 build: back-to-back reads of 0x00, 0x04, 0x08, each held 2 cycles → `mem_ready` pulses 1 on the second cycle of each, with correct data.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Byte-addressed data memory that answers the cache's word-wide fill and
// write-back traffic after a fixed access latency. The core provides no
// request strobe. A new request is therefore detected by comparing the live
// request with the last captured one.
//
// Parameters:
//   ADDR_BITS    - storage holds 2**ADDR_BITS bytes; higher address bits wrap
//   LATENCY      - edges from request capture to completion (>= 1)
//
// Ports:
//   clk          - rising-edge clock
//   rst_b        - asynchronous active-low reset
//   mem_addr     - byte address; bits [1:0] and bits above ADDR_BITS ignored
//   mem_data_in  - write data, lane i -> byte base+i
//   mem_write_en - 1 = write request, 0 = read request
//   mem_data_out - read data / written data, lane i = byte base+i
//   mem_ready    - current request has completed; mem_data_out valid
module data_memory_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_BITS-1:0]  cap_word_q, cap_word_d;
  logic                  cap_we_q, cap_we_d;
  logic [0:3][7:0]       cap_data_q, cap_data_d;
  logic                  ready_q, ready_d;
  logic [0:3][7:0]       data_out_q, data_out_d;

  logic [7:0]            mem [0:(1 << ADDR_BITS) - 1];

  logic [WORD_BITS-1:0]  live_word;
  logic [0:3][7:0]       live_data;
  logic                  req_changed;
  logic                  capture;
  logic                  complete;
  logic                  mem_we;
  logic                  unused_addr;

  // Write data only belongs to the request when writing, so read requests
  // carry zeros and their data lanes can wiggle without being seen as new.
  assign live_word   = mem_addr[ADDR_BITS-1:2];
  assign live_data   = mem_write_en ? mem_data_in : '0;
  assign req_changed = (live_word != cap_word_q) ||
                       (mem_write_en != cap_we_q) ||
                       (live_data != cap_data_q);
  assign unused_addr = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

  // State register plus captured request, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cap_word_q <= '0;
      cap_we_q   <= 1'b0;
      cap_data_q <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_word_q <= cap_word_d;
      cap_we_q   <= cap_we_d;
      cap_data_q <= cap_data_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
    end
  end

  // Next-state logic: capture a request on entry or whenever it changes,
  // count down the latency, and complete once the count reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = 1'b1;
        cnt_d   = CNT_RELOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (req_changed) begin
          capture = 1'b1;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (req_changed) begin
          capture = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cap_word_d = capture ? live_word    : cap_word_q;
    cap_we_d   = capture ? mem_write_en : cap_we_q;
    cap_data_d = capture ? live_data    : cap_data_q;
  end

  // Output logic. Completion only happens while the live request equals the
  // captured one, so the captured copy is what gets written or read. A write
  // fires exactly once because DONE never completes again.
  always_comb begin
    ready_d    = ready_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    if (capture) begin
      ready_d = 1'b0;
    end
    if (complete) begin
      ready_d = 1'b1;
      if (cap_we_q) begin
        mem_we     = 1'b1;
        data_out_d = cap_data_q;
      end else begin
        for (int i = 0; i < 4; i++) begin
          data_out_d[i] = mem[{cap_word_q, 2'(i)}];
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        mem[{cap_word_q, 2'(i)}] <= cap_data_q[i];
      end
    end
  end

  assign mem_ready    = ready_q;
  assign mem_data_out = data_out_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//
// Scoreboard bench for data_memory_responder. Each request that is held long
// enough to complete pushes its expected data and completion cycle into a
// queue. A monitor pops one entry on every rising edge of mem_ready.
module tb_data_memory_responder;

  localparam int ADDR_BITS = 12;
  localparam int LAT       = 4;
  localparam logic [31:0] ADDR_KEEP = 32'((1 << ADDR_BITS) - 1) & ~32'h3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_b = 1'b1;
  logic [31:0]     mem_addr = '0;
  logic [0:3][7:0] mem_data_in = '0;
  logic            mem_write_en = 1'b0;
  logic [0:3][7:0] mem_data_out;
  logic            mem_ready;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic        prev_ready = 1'b0;
  logic [7:0]  mdl [int];
  int          last_base = -1;
  logic        last_we = 1'b0;
  logic [31:0] last_kdata = '0;

  data_memory_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive one request and keep it live for 'hold' edges. While held, only
  // bits the responder must ignore are disturbed. The request only completes
  // if it stays live for the capture edge plus LAT further edges.
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [0:3][7:0] data, input int hold);
    int              base;
    logic [0:3][7:0] expd;
    exp_t            e;
    mem_addr     = addr;
    mem_write_en = we;
    mem_data_in  = data;
    base         = int'(addr & ADDR_KEEP);
    last_base    = base;
    last_we      = we;
    last_kdata   = we ? data : 32'h0;
    if (hold >= LAT + 1) begin
      if (we) begin
        for (int i = 0; i < 4; i++) mdl[base + i] = data[i];
        expd = data;
      end else begin
        for (int i = 0; i < 4; i++) expd[i] = mdl[base + i];
      end
      e.data = expd;
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (k < hold - 1) begin
        mem_addr = (mem_addr & ADDR_KEEP) | ($urandom() & ~ADDR_KEEP);
        if (!we) mem_data_in = $urandom();
      end
    end
  endtask

  // Monitor: every rising edge of mem_ready must match the oldest expectation
  // in both data and completion cycle.
  always @(negedge clk) begin
    if (mem_ready === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_completion", 32'(mem_ready), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("read_data", mem_data_out, mon_e.data);
        checkOutput("completion_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    prev_ready = mem_ready;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int              w;
    logic            we;
    logic [0:3][7:0] d;
    logic [31:0]     kd;

    // Power-on reset.
    #2 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(mem_ready), 32'h0);
    checkOutput("reset_data", mem_data_out, 32'h0);
    rst_b = 1'b1;

    // Preload the 16 words used by the rest of the run.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'(i * 4), 1'b1, $urandom(), LAT + 1);
    end

    // Write then read back the same word without an idle cycle.
    applyStimulus(32'h10, 1'b1, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, LAT + 2);
    applyStimulus(32'h10, 1'b0, 32'h0, LAT + 1);

    // Asynchronous reset in the middle of a pending write.
    applyStimulus(32'h14, 1'b1, {8'h01, 8'h02, 8'h03, 8'h04}, 2);
    rst_b = 1'b0;
    #1;
    checkOutput("midwait_reset_ready", 32'(mem_ready), 32'h0);
    checkOutput("midwait_reset_data", mem_data_out, 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    applyStimulus(32'h14, 1'b0, 32'h0, LAT + 1);

    // Restart: read abandoned after 2 edges in favour of another word.
    applyStimulus(32'h20, 1'b0, 32'h0, 2);
    applyStimulus(32'h24, 1'b0, 32'h0, LAT + 1);

    // Abandoned write must leave the word untouched.
    applyStimulus(32'h30, 1'b1, {8'h11, 8'h22, 8'h33, 8'h44}, 1);
    applyStimulus(32'h30, 1'b0, 32'h0, LAT + 1);

    // Aliasing: 0x1002 is word 0; ignored bits toggle while in DONE.
    applyStimulus(32'h1002, 1'b0, 32'h0, LAT + 1);
    for (int i = 0; i < 4; i++) begin
      mem_addr    = $urandom() & ~ADDR_KEEP;
      mem_data_in = $urandom();
      @(posedge clk);
      #1;
      checkOutput("alias_ready_held", 32'(mem_ready), 32'h1);
    end

    // Random traffic; each request differs from the previous one.
    for (int n = 0; n < 50; n++) begin
      do begin
        w  = int'($urandom_range(0, 15));
        we = 1'($urandom_range(0, 1));
        d  = $urandom();
        kd = we ? d : 32'h0;
      end while (w * 4 == last_base && we == last_we && kd == last_kdata);
      applyStimulus(($urandom() & ~ADDR_KEEP) | 32'(w * 4), we, d,
                    int'($urandom_range(1, LAT + 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
